// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg: shared FSM states, error-cause codes and slave-count limits for the bus fabric
package bus_fabric_pkg;
  localparam int MAX_SLAVES = 16;
  localparam int IDX_W = $clog2(MAX_SLAVES);
  localparam logic CAUSE_UNMAPPED = 1'b0;
  localparam logic CAUSE_TIMEOUT = 1'b1;
  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;
endpackage

// File: rtl/bus_addr_match.sv
// bus_addr_match: combinational base/mask decode of addr into hit and lowest-index matching slave idx
module bus_addr_match import bus_fabric_pkg::*; #(
  parameter int NUM_SLAVES = 10,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: CPU-to-N-slave decoder with timeout, error responses and sticky error status (mem_* CPU side, slv_* slave side, err_* status)
module bus_fabric import bus_fabric_pkg::*; #(
  parameter int NUM_SLAVES = 10,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    slv_sel,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  input  logic                     err_clear,
  output logic                     err_flag,
  output logic                     err_cause,
  output logic [31:0]              err_addr,
  output logic                     err_irq
);
  state_t state;
  logic [IDX_W-1:0] idx, hit_idx;
  logic hit, rdy, tmo, err_evt;
  logic [31:0] cnt, addr_q, sel_data;
  bus_addr_match #(
    .NUM_SLAVES(NUM_SLAVES),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_match (
    .addr(mem_addr),
    .hit (hit),
    .idx (hit_idx)
  );
  always_comb begin
    slv_sel = state == ACTIVE ? NUM_SLAVES'(1) << idx : '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      sel_data = slv_sel[i] ? sel_data | slv_rdata[32*i +: 32] : sel_data;
    rdy = !reset && state == ACTIVE && mem_valid && |(slv_ready & slv_sel);
    tmo = !reset && state == ACTIVE && mem_valid && !rdy && TIMEOUT_CYCLES != 0 &&
          cnt == 32'(TIMEOUT_CYCLES - 1);
    err_evt = !reset && (state == ERR || tmo);
    mem_ready = rdy || err_evt;
    mem_rdata = rdy ? sel_data : err_evt ? ERR_RDATA : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      addr_q <= '0;
      err_flag <= 1'b0;
      err_cause <= CAUSE_UNMAPPED;
      err_addr <= '0;
      err_irq <= 1'b0;
    end else begin
      err_irq <= err_evt;
      if (err_evt) begin
        err_flag <= 1'b1;
        if (!err_flag || err_clear) begin
          err_cause <= tmo ? CAUSE_TIMEOUT : CAUSE_UNMAPPED;
          err_addr <= addr_q;
        end
      end else if (err_clear)
        err_flag <= 1'b0;
      case (state)
        IDLE: if (mem_valid) begin
          addr_q <= mem_addr;
          idx <= hit_idx;
          cnt <= '0;
          state <= hit ? ACTIVE : ERR;
        end
        ACTIVE: begin
          cnt <= cnt + 32'd1;
          state <= (!mem_valid || mem_ready) ? IDLE : ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: scoreboard bench for bus_fabric with three slaves and an 8-cycle timeout
module tb_bus_fabric;
  localparam logic [95:0] BASE = {32'h8000_0000, 32'h0002_0000, 32'h8000_0000};
  localparam logic [95:0] MASK = {32'hFF00_0000, 32'hFFFF_E000, 32'hFFFF_0000};
  localparam logic [31:0] D0 = 32'hA0A0_0000, D1 = 32'hB1B1_1111, D2 = 32'hC2C2_2222;
  logic clk = 0, reset = 1, mem_valid = 0, mem_ready, err_clear = 0;
  logic err_flag, err_cause, err_irq;
  logic [31:0] mem_addr = 0, mem_rdata, err_addr;
  logic [2:0] slv_sel, slv_ready = 0;
  logic [95:0] slv_rdata = {D2, D1, D0};
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  bus_fabric #(
    .NUM_SLAVES(3), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .slv_sel(slv_sel), .slv_ready(slv_ready), .slv_rdata(slv_rdata),
    .err_clear(err_clear), .err_flag(err_flag), .err_cause(err_cause), .err_addr(err_addr),
    .err_irq(err_irq)
  );
  always #5 clk = ~clk;
  task automatic do_read(input logic [31:0] a, input int rdy_cyc, input logic [2:0] esel,
                         input logic [31:0] edata, input int elat, input logic eerr, input logic clr);
    int cyc = 0;
    bit done = 0;
    logic [31:0] want;
    mem_addr = a; mem_valid = 1; err_clear = clr; slv_ready = ~esel;
    exp_q.push_back(edata);
    while (!done && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      slv_ready = (cyc == rdy_cyc) ? 3'b111 : ~esel;
      #1;
      done = mem_ready;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL read_timeout addr=%h no mem_ready within 40 cycles", a);
      exp_q.delete();
    end else begin
      want = exp_q.pop_front();
      total++;
      if (mem_rdata !== want) begin bad++; $display("FAIL rdata addr=%h got=%h exp=%h", a, mem_rdata, want); end
      total++;
      if (cyc !== elat) begin bad++; $display("FAIL latency addr=%h got=%0d exp=%0d", a, cyc, elat); end
      total++;
      if (slv_sel !== esel) begin bad++; $display("FAIL sel addr=%h got=%b exp=%b", a, slv_sel, esel); end
    end
    @(posedge clk); #1;
    mem_valid = 0; slv_ready = 0; err_clear = 0;
    total++;
    if (err_irq !== eerr) begin bad++; $display("FAIL irq addr=%h got=%b exp=%b", a, err_irq, eerr); end
    total++;
    if (slv_sel !== 3'b000) begin bad++; $display("FAIL sel_after addr=%h got=%b exp=000", a, slv_sel); end
    @(posedge clk); #1;
    total++;
    if (err_irq !== 1'b0) begin bad++; $display("FAIL irq_pulse addr=%h got=%b exp=0", a, err_irq); end
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1; reset = 0; #1;
    total++;
    if ({mem_ready, mem_rdata, slv_sel} !== 36'd0) begin
      bad++; $display("FAIL reset_bus got=%b/%h/%b exp=0/0/0", mem_ready, mem_rdata, slv_sel);
    end
    total++;
    if ({err_flag, err_cause, err_addr, err_irq} !== 35'd0) begin
      bad++; $display("FAIL reset_err got=%b/%b/%h/%b exp=0/0/0/0", err_flag, err_cause, err_addr, err_irq);
    end
  endtask
  task automatic test_decode;
    do_read(32'h0002_0010, 3, 3'b010, D1, 3, 0, 0);
    do_read(32'h8000_0000, 1, 3'b001, D0, 1, 0, 0);
    do_read(32'h8010_0000, 2, 3'b100, D2, 2, 0, 0);
  endtask
  task automatic check_err(input string n, input logic ef, input logic ec, input logic [31:0] ea);
    total++;
    if ({err_flag, err_cause, err_addr} !== {ef, ec, ea}) begin
      bad++; $display("FAIL %s got=%b/%b/%h exp=%b/%b/%h", n, err_flag, err_cause, err_addr, ef, ec, ea);
    end
  endtask
  task automatic test_unmapped;
    do_read(32'h4000_0000, 0, 3'b000, 32'hDEAD_BEEF, 1, 1, 0);
    check_err("unmapped_status", 1, 0, 32'h4000_0000);
  endtask
  task automatic test_timeout;
    do_read(32'h0002_0000, 0, 3'b010, 32'hDEAD_BEEF, 8, 1, 0);
    check_err("sticky_status", 1, 0, 32'h4000_0000);
    @(negedge clk); err_clear = 1;
    @(negedge clk); err_clear = 0;
    check_err("cleared_status", 0, 0, 32'h4000_0000);
    do_read(32'h0002_0004, 0, 3'b010, 32'hDEAD_BEEF, 8, 1, 0);
    check_err("timeout_status", 1, 1, 32'h0002_0004);
    do_read(32'h0002_0008, 8, 3'b010, D1, 8, 0, 0);
    check_err("ready_at_expiry", 1, 1, 32'h0002_0004);
  endtask
  task automatic test_clear_coincide;
    do_read(32'h5000_0000, 0, 3'b000, 32'hDEAD_BEEF, 1, 1, 1);
    check_err("clear_coincide", 1, 0, 32'h5000_0000);
  endtask
  task automatic test_back_to_back;
    int cyc = 0, pulses = 0, second = 0;
    logic [31:0] want;
    mem_addr = 32'h0002_0000; mem_valid = 1; slv_ready = 3'b111;
    exp_q.push_back(D1); exp_q.push_back(D0);
    while (pulses < 2 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (pulses == 1) mem_addr = 32'h8000_0004;
      #1;
      if (mem_ready) begin
        pulses++;
        second = cyc;
        want = exp_q.pop_front();
        total++;
        if (mem_rdata !== want) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", mem_rdata, want); end
      end
    end
    @(posedge clk); #1; mem_valid = 0; slv_ready = 0;
    total++;
    if (second !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", second); end
    @(posedge clk); #1;
  endtask
  task automatic test_abort;
    mem_addr = 32'h0002_0010; mem_valid = 1; slv_ready = 0;
    @(posedge clk); #1;
    total++;
    if (slv_sel !== 3'b010) begin bad++; $display("FAIL abort_sel got=%b exp=010", slv_sel); end
    @(posedge clk); #1; mem_valid = 0; #1;
    total++;
    if (mem_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", mem_ready); end
    @(posedge clk); #1;
    total++;
    if ({slv_sel, mem_ready, err_irq} !== 5'd0) begin
      bad++; $display("FAIL abort_idle got=%b/%b/%b exp=000/0/0", slv_sel, mem_ready, err_irq);
    end
  endtask
  task automatic test_reset_mid;
    mem_addr = 32'h0002_0010; mem_valid = 1; slv_ready = 0;
    @(posedge clk); #1;
    reset = 1; slv_ready = 3'b111; #1;
    total++;
    if ({mem_ready, mem_rdata} !== 33'd0) begin
      bad++; $display("FAIL reset_mid_ready got=%b/%h exp=0/0", mem_ready, mem_rdata);
    end
    @(posedge clk); #1;
    reset = 0; mem_valid = 0; slv_ready = 0;
    total++;
    if ({slv_sel, err_flag} !== 4'd0) begin
      bad++; $display("FAIL reset_mid_sel got=%b/%b exp=000/0", slv_sel, err_flag);
    end
  endtask
  initial begin
    test_reset;
    test_decode;
    test_unmapped;
    test_timeout;
    test_clear_coincide;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 10: number of slave ports, legal range 1..16.
REQ-002 SHALL have parameter SLAVE_BASE, default all-zero, NUM_SLAVES*32 bits: packed base addresses, slot i at [32*i+31:32*i].
REQ-003 SHALL have parameter SLAVE_MASK, default all-zero, NUM_SLAVES*32 bits: packed address masks, same slot layout as SLAVE_BASE.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles in ACTIVE before an error response; 0 disables the timeout.
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on an error response.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; one clock only.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port mem_valid, input, 1 bit: CPU request valid.
REQ-009 SHALL have port mem_addr, input, 32 bits: CPU byte address.
REQ-010 SHALL have port mem_ready, output, 1 bit: transfer complete, one-cycle pulse.
REQ-011 SHALL have port mem_rdata, output, 32 bits: read data to the CPU.
REQ-012 SHALL have port slv_sel, output, NUM_SLAVES bits: one-hot slave select.
REQ-013 SHALL have port slv_ready, input, NUM_SLAVES bits: per-slave ready.
REQ-014 SHALL have port slv_rdata, input, NUM_SLAVES*32 bits: packed slave read data, slot i at [32*i+31:32*i].
REQ-015 SHALL have port err_clear, input, 1 bit: clears the error status.
REQ-016 SHALL have port err_flag, output, 1 bit: sticky error-present flag.
REQ-017 SHALL have port err_cause, output, 1 bit: error cause, 0 = unmapped address, 1 = timeout.
REQ-018 SHALL have port err_addr, output, 32 bits: address of the captured error.
REQ-019 SHALL have port err_irq, output, 1 bit: one-cycle pulse per error.

Function
REQ-020 SHALL decode slave i as a hit when (mem_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]; on overlapping hits the lowest index wins.
REQ-021 SHALL implement a state machine with states IDLE, ACTIVE and ERR.
REQ-022 SHALL, in IDLE with mem_valid=1: on a hit, register the slave index, clear the timeout counter and go to ACTIVE; on no hit, go to ERR.
REQ-023 SHALL drive slv_sel[idx]=1 only while in ACTIVE; slv_sel SHALL be 0 in IDLE and ERR and SHALL stay stable throughout a transaction.
REQ-024 SHALL, in ACTIVE with slv_ready[idx]=1: assert mem_ready combinationally in that cycle, drive mem_rdata from slot idx, and return to IDLE.
REQ-025 SHALL ignore slv_ready bits of unselected slaves.
REQ-026 SHALL give a minimum latency of mem_valid at cycle 0, mem_ready at cycle 1; back-to-back requests SHALL be accepted in the cycle after mem_ready.
REQ-027 SHALL increment the timeout counter every ACTIVE cycle without ready; when the counter equals TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES nonzero), it SHALL assert mem_ready with ERR_RDATA, record a timeout error and go to IDLE.
REQ-028 SHALL treat slave ready in the same cycle as timeout expiry as a normal completion, with no error recorded.
REQ-029 SHALL, in ERR, last exactly one cycle: assert mem_ready, drive mem_rdata=ERR_RDATA, record an unmapped error, then go to IDLE.
REQ-030 SHALL, when mem_valid falls while in ACTIVE, abort to IDLE with no mem_ready and no error.
REQ-031 SHALL drive mem_rdata=0 whenever mem_ready=0.
REQ-032 SHALL, on an error with err_flag=0, set err_flag and capture err_cause and err_addr (the transaction address); later errors SHALL NOT overwrite them while err_flag=1.
REQ-033 SHALL clear err_flag on err_clear; when err_clear coincides with an error, the new error SHALL be captured and err_flag SHALL remain 1.
REQ-034 SHALL pulse err_irq for one cycle on every error, independent of err_flag.

Reset
REQ-035 SHALL, on reset, set state=IDLE, timeout counter=0, slv_sel=0, mem_ready=0, mem_rdata=0, err_flag=0, err_cause=0, err_addr=0 and err_irq=0.
REQ-036 SHALL, on reset asserted mid-transaction, abandon the transaction without a mem_ready pulse; reset SHALL take priority over all other inputs.

Structure
REQ-037 SHALL keep the state encoding, the err_cause constants and the maximum slave count (16) in a shared package, bus_fabric_pkg.
REQ-038 SHALL place address matching and priority encoding in one combinational sub-module, bus_addr_match, which outputs hit and index.

Verification
REQ-039 SHALL cover: with NUM_SLAVES=3 and slave 1 at base 0x0002_0000, mask 0xFFFF_E000, a read of 0x0002_0010 with slave ready after 2 cycles -> slv_sel=3'b010, mem_ready at cycle 3, mem_rdata equal to slave 1 data.
REQ-040 SHALL cover: a read of 0x4000_0000 (no hit) -> mem_ready at cycle 1, mem_rdata=0xDEAD_BEEF, err_flag=1, err_cause=0, err_addr=0x4000_0000, one err_irq pulse.
REQ-041 SHALL cover: with TIMEOUT_CYCLES=8 and the slave never ready -> mem_ready after 8 ACTIVE cycles, err_cause=1, slv_sel returns to 0.
REQ-042 SHALL cover: with TIMEOUT_CYCLES=8 and slave ready in exactly the 8th ACTIVE cycle -> normal slave data, err_irq stays 0.
REQ-043 SHALL cover: overlapping slaves 0 and 2 both hitting 0x8000_0000 -> slv_sel=3'b001.
REQ-044 SHALL cover: err_clear asserted in the same cycle as a second unmapped access -> err_flag stays 1, err_addr holds the second address; and reset asserted in ACTIVE -> slv_sel=0 next cycle with no mem_ready pulse.
